// File: rtl/led_fade_driver.sv
// led_fade_driver: per-LED 8-bit PWM with linear fade between off and a
// global brightness, driven from the LED register's on/off word.
module led_fade_driver #(
  parameter int PRESCALE_DIV = 64,
  parameter int FADE_STEP    = 8
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       EN,
  input  logic [7:0] LED_IN,
  input  logic [7:0] BRIGHTNESS,
  output logic [7:0] LED_OUT,
  output logic       PERIOD_STROBE
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE_DIV - 1);
  localparam logic [8:0]  STEP    = 9'(FADE_STEP);

  logic [15:0] pre;
  logic [7:0]  cnt;
  logic [7:0]  lvl [8];
  logic [7:0]  nxt [8];
  logic        tick;
  logic        pend;

  assign tick = EN && (pre == PRE_MAX);
  assign pend = tick && (cnt == 8'd254);

  // 9-bit compare against the target keeps the step from wrapping or
  // overshooting in either direction.
  function automatic logic [7:0] fade(
    input logic [7:0] l,
    input logic [7:0] t
  );
    logic [8:0] up;
    logic [8:0] dn;
    logic [8:0] lim;
    up  = {1'b0, l} + STEP;
    dn  = {1'b0, l} - STEP;
    lim = {1'b0, t} + STEP;
    fade = l;
    if (STEP == 9'd0) begin
      fade = t;
    end else if (l < t) begin
      fade = (up > {1'b0, t}) ? t : up[7:0];
    end else if (l > t) begin
      fade = ({1'b0, l} <= lim) ? t : dn[7:0];
    end
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      nxt[i] = fade(lvl[i], LED_IN[i] ? BRIGHTNESS : 8'd0);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre           <= '0;
      cnt           <= '0;
      LED_OUT       <= '0;
      PERIOD_STROBE <= 1'b0;
      for (int i = 0; i < 8; i++) lvl[i] <= '0;
    end else if (!EN) begin
      pre           <= '0;
      cnt           <= '0;
      LED_OUT       <= '0;
      PERIOD_STROBE <= 1'b0;
      for (int i = 0; i < 8; i++) lvl[i] <= '0;
    end else begin
      pre <= tick ? 16'd0 : pre + 16'd1;
      if (tick) begin
        cnt <= (cnt == 8'd254) ? 8'd0 : cnt + 8'd1;
      end
      for (int i = 0; i < 8; i++) begin
        if (pend) lvl[i] <= nxt[i];
        LED_OUT[i] <= (cnt < lvl[i]);
      end
      PERIOD_STROBE <= pend;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: instant and faded instances share
// stimulus; high time per period is counted against hand-derived values.
module tb_led_fade_driver;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       EN = 1'b0;
  logic [7:0] LED_IN = 8'h00;
  logic [7:0] BRIGHTNESS = 8'h00;
  logic [7:0] lo_a;
  logic [7:0] lo_b;
  logic       so_a;
  logic       so_b;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  led_fade_driver #(.PRESCALE_DIV(2), .FADE_STEP(0)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .EN(EN),
    .LED_IN(LED_IN), .BRIGHTNESS(BRIGHTNESS),
    .LED_OUT(lo_a), .PERIOD_STROBE(so_a)
  );

  led_fade_driver #(.PRESCALE_DIV(2), .FADE_STEP(100)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .EN(EN),
    .LED_IN(LED_IN), .BRIGHTNESS(BRIGHTNESS),
    .LED_OUT(lo_b), .PERIOD_STROBE(so_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (n < 1000) begin
      @(negedge PCLK);
      n++;
      if (so_a) break;
    end
    check(tag, n, 510);
  endtask

  // Starts on a strobe cycle, ends on the next one (510 cycles later).
  task automatic period(
    input string tag,
    input int ea0, input int ea7,
    input int eb0, input int eb7,
    input int chg_at, input logic [7:0] chg_b
  );
    int a0, a7, b0, b7, oth, sbad;
    a0 = 0; a7 = 0; b0 = 0; b7 = 0; oth = 0; sbad = 0;
    for (int i = 0; i < 510; i++) begin
      if (i == chg_at) BRIGHTNESS = chg_b;
      @(negedge PCLK);
      a0 += int'(lo_a[0]);
      a7 += int'(lo_a[7]);
      b0 += int'(lo_b[0]);
      b7 += int'(lo_b[7]);
      if (lo_a[6:1] != 6'd0 || lo_b[6:1] != 6'd0) oth++;
      if (so_a !== (i == 509) || so_b !== (i == 509)) sbad++;
    end
    check({tag, " a0"}, a0, ea0);
    check({tag, " a7"}, a7, ea7);
    check({tag, " b0"}, b0, eb0);
    check({tag, " b7"}, b7, eb7);
    check({tag, " other"}, oth, 0);
    check({tag, " strobe"}, sbad, 0);
  endtask

  initial begin
    int bad;
    #1 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst lo_a", int'(lo_a), 0);
    check("rst lo_b", int'(lo_b), 0);
    check("rst so_a", int'(so_a), 0);
    check("rst so_b", int'(so_b), 0);
    PRESETn = 1'b1;
    bad = 0;
    repeat (600) begin
      @(negedge PCLK);
      if (lo_a != 8'd0 || lo_b != 8'd0 || so_a || so_b) bad++;
    end
    check("idle en0", bad, 0);

    BRIGHTNESS = 8'd255;
    LED_IN = 8'h01;
    EN = 1'b1;
    wait_strobe("first strobe");
    period("p1", 510, 0, 200, 0, -1, 8'd0);
    period("p2", 510, 0, 400, 0, -1, 8'd0);
    period("p3", 510, 0, 510, 0, -1, 8'd0);
    LED_IN = 8'h00;
    period("p4", 510, 0, 510, 0, -1, 8'd0);
    period("p5", 0, 0, 310, 0, -1, 8'd0);
    period("p6", 0, 0, 110, 0, -1, 8'd0);
    period("p7", 0, 0, 0, 0, -1, 8'd0);
    BRIGHTNESS = 8'd64;
    LED_IN = 8'h81;
    period("p8", 0, 0, 0, 0, -1, 8'd0);
    period("p9", 128, 128, 128, 128, -1, 8'd0);
    BRIGHTNESS = 8'd255;
    LED_IN = 8'h01;
    period("p10", 128, 128, 128, 128, -1, 8'd0);
    period("p11", 510, 0, 328, 0, -1, 8'd0);
    period("p12 midchg", 510, 0, 510, 0, 200, 8'd10);
    period("p13", 20, 0, 310, 0, -1, 8'd0);

    repeat (6) @(negedge PCLK);
    check("pre en0 lo_a", int'(lo_a), 1);
    check("pre en0 lo_b", int'(lo_b), 1);
    EN = 1'b0;
    @(negedge PCLK);
    check("en0 lo_a", int'(lo_a), 0);
    check("en0 lo_b", int'(lo_b), 0);
    bad = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (lo_a != 8'd0 || lo_b != 8'd0 || so_a || so_b) bad++;
    end
    check("en0 hold", bad, 0);

    BRIGHTNESS = 8'd255;
    EN = 1'b1;
    wait_strobe("reen strobe");
    period("re1", 510, 0, 200, 0, -1, 8'd0);
    repeat (10) @(negedge PCLK);
    check("pre rst lo_a", int'(lo_a), 1);
    check("pre rst lo_b", int'(lo_b), 1);
    #2 PRESETn = 1'b0;
    #1;
    check("async lo_a", int'(lo_a), 0);
    check("async lo_b", int'(lo_b), 0);
    check("async so_b", int'(so_b), 0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    wait_strobe("post rst strobe");
    period("pr1", 510, 0, 200, 0, -1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage placed directly downstream of the APB LED register: consumes its 8-bit LED on/off word and drives the physical LED pins with per-LED 8-bit PWM dimming and a linear fade between off and a global brightness level. It runs entirely on PCLK and has no bus interface. The LED register's output connects to LED_IN; LED_OUT goes to the board pins.

## Interface
Parameters:
- PRESCALE_DIV, 64: PCLK cycles per PWM tick, legal range 1..65535.
- FADE_STEP, 8: level change per PWM period, range 0..255. 0 means instant (no fade).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- EN  in  1  driver enable. Low forces all outputs off and clears all state.
- LED_IN  in  8  on/off request per LED, from the LED register.
- BRIGHTNESS  in  8  target duty for LEDs that are on. 255 means fully on.
- LED_OUT  out  8  PWM pin drive, registered.
- PERIOD_STROBE  out  1  one-cycle pulse at the start of each PWM period, registered.

## Operation
- Prescaler `pre`, 16 bits:
  - counts 0..PRESCALE_DIV-1, then wraps;
  - `tick` = EN & (pre == PRESCALE_DIV-1).
- PWM counter `cnt`, 8 bits:
  - counts 0..254 (period = 255 ticks);
  - increments on `tick`;
  - wraps 254→0.
- Period end `pend` = `tick` & (cnt == 254).
- Per-LED level register `lvl[i]`, 8 bits. Updates only on `pend`:
  - target t = LED_IN[i] ? BRIGHTNESS : 0;
  - FADE_STEP == 0: lvl ← t;
  - lvl < t: lvl ← min(lvl + FADE_STEP, t);
  - lvl > t: lvl ← max(lvl − FADE_STEP, t);
  - arithmetic is 9-bit, so there is no wrap and no overshoot.
- LED_IN and BRIGHTNESS are sampled only on `pend`. Changes mid-period have no effect until the next period end.
- LED_OUT[i] ← EN & (cnt < lvl[i]):
  - lvl = 0 gives constantly off;
  - lvl = 255 gives constantly on;
  - lvl = k gives on for ticks 0..k−1 of each period.
- PERIOD_STROBE ← `pend`. High during the first cycle in which cnt == 0 and the new lvl values are visible.
- EN low, synchronous: pre, cnt and every lvl clear to 0; LED_OUT and PERIOD_STROBE go 0 on the next edge.
- EN rising: counting restarts from pre = 0, cnt = 0, lvl = 0. LEDs fade in from 0 starting at the first period end.
- PRESETn low: pre, cnt, lvl, LED_OUT and PERIOD_STROBE all go 0 immediately, including mid-period and mid-fade.

## Timing
- Reset values: LED_OUT = 8'h00, PERIOD_STROBE = 0.
- PWM period = 255 × PRESCALE_DIV PCLK cycles.
- Pin resolution = PRESCALE_DIV cycles.
- LED_OUT lags cnt/lvl by 1 cycle (registered compare).
- LED_IN to pin latency: from 1 cycle up to one full period plus 1 cycle, depending on period phase.
- Fade duration from 0 to B: ceil(B / FADE_STEP) periods. Fade down is symmetric.
- Simultaneous cases:
  - LED_IN toggling on the `pend` cycle: the value present on that cycle is used.
  - EN low on the `pend` cycle: EN wins, and all state clears.
- PRESCALE_DIV = 1: tick every enabled cycle; the compare still has 1-cycle latency.

## Test plan
All scenarios use PRESCALE_DIV = 2, so one period = 510 cycles.
- Reset: PRESETn low → LED_OUT = 00, PERIOD_STROBE = 0. Release with EN = 0 → both stay 0 indefinitely.
- Instant full-on: FADE_STEP = 0, BRIGHTNESS = 255, LED_IN = 8'h01, EN = 1:
  - PERIOD_STROBE pulses every 510 cycles;
  - after the first strobe, LED_OUT = 8'h01 constantly.
- Duty: FADE_STEP = 0, BRIGHTNESS = 64, LED_IN = 8'h81:
  - LED_OUT[7] and LED_OUT[0] are high exactly 128 of every 510 cycles, starting 1 cycle after the strobe;
  - other bits stay 0.
- Fade with saturation: FADE_STEP = 100, BRIGHTNESS = 255, LED_IN = 01:
  - lvl[0] goes 100, 200, 255 over 3 periods; high time is 200, 400, then 510 cycles (constantly on);
  - then LED_IN = 00: lvl goes 155, 55, 0.
- Mid-period changes:
  - change BRIGHTNESS 255→10 at cnt = 100 → current period unaffected, new duty from the next strobe;
  - EN low mid-period → LED_OUT = 00 next cycle;
  - EN high again → fade restarts from 0.
- Async reset mid-fade (lvl = 200): assert PRESETn → LED_OUT = 00 without a clock edge. After release, lvl restarts at 0.
